keypad_entry_controller: RTL and testbench

- Sequences the keypad scanner's key_code/key_held outputs into clean single-shot key events using press and release debounce.
- Assembles up to four digits plus an AM/PM flag into an HH:MM entry buffer.
- On a Set Time or Set Alarm key it validates the entry and issues a one-cycle load pulse with the committed value.
- Sits between the keypad scanner and the timekeeping/alarm registers.

---
 rtl/keypad_entry_controller_if.sv | 29 ++
 rtl/keypad_entry_controller.sv | 184 ++++++++++++++++++
 tb/tb_keypad_entry_controller.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_controller_if.sv
// Keypad entry bus: scanner-side key inputs plus the live entry buffer,
// the committed time value and the load/error strobes.
interface keypad_entry_controller_if;
   logic [3:0]  key_code;
   logic        key_held;
   logic [15:0] entry_digits;
   logic        entry_pm;
   logic [2:0]  digit_count;
   logic        entry_active;
   logic [15:0] set_value;
   logic        set_pm;
   logic        load_time;
   logic        load_alarm;
   logic        entry_error;

   // Scanner / consumer side: drives keys, observes the controller.
   modport master (
      output key_code, key_held,
      input  entry_digits, entry_pm, digit_count, entry_active,
             set_value, set_pm, load_time, load_alarm, entry_error
   );

   // Controller side: consumes keys, produces entry and commit results.
   modport slave (
      input  key_code, key_held,
      output entry_digits, entry_pm, digit_count, entry_active,
             set_value, set_pm, load_time, load_alarm, entry_error
   );
endinterface

// File: rtl/keypad_entry_controller.sv
// Keypad entry controller: debounces scanner key events into single-shot
// actions, builds an HH:MM + AM/PM entry and commits it to the time or
// alarm registers after validation. Partial entries expire after TIMEOUT.
module keypad_entry_controller #(
   parameter int unsigned DEBOUNCE = 3,
   parameter int unsigned TIMEOUT  = 2560
) (
   input  logic                             clk_256Hz,
   input  logic                             reset_n,
   keypad_entry_controller_if.slave         kbus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESS   = 2'd1,
      ST_EXEC    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   localparam logic [3:0]  DEB_L = 4'(DEBOUNCE);
   localparam logic [11:0] TMO_L = 12'(TIMEOUT);

   localparam logic [3:0] KEY_AMPM  = 4'hA;
   localparam logic [3:0] KEY_TIME  = 4'hB;
   localparam logic [3:0] KEY_ALARM = 4'hC;

   state_t      state_r;
   logic [3:0]  cnt_r;
   logic [11:0] timer_r;
   logic [15:0] entry_digits_r;
   logic        entry_pm_r;
   logic [2:0]  digit_count_r;
   logic        entry_active_r;
   logic [15:0] set_value_r;
   logic        set_pm_r;
   logic        load_time_r;
   logic        load_alarm_r;
   logic        entry_error_r;
   logic        accept_s;
   logic        is_digit_s;
   logic        entry_valid_s;

   // Entry is committable when it has at least HMM, hour is 1..12,
   // minute tens is 0..5 and every nibble is a BCD digit.
   function automatic logic commit_ok(input logic [15:0] d, input logic [2:0] n);
      logic [6:0] hour;
      logic       bcd_ok;
      hour   = ({3'd0, d[15:12]} * 7'd10) + {3'd0, d[11:8]};
      bcd_ok = (d[15:12] <= 4'd9) && (d[11:8] <= 4'd9) &&
               (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9);
      return (n >= 3'd3) && bcd_ok && (hour >= 7'd1) && (hour <= 7'd12) &&
             (d[7:4] <= 4'd5);
   endfunction

   // Key decode of the code being executed this cycle.
   assign is_digit_s    = (kbus.key_code <= 4'd9);
   assign accept_s      = (state_r == ST_EXEC) && (kbus.key_code <= KEY_ALARM);
   assign entry_valid_s = commit_ok(entry_digits_r, digit_count_r);

   // Debounce FSM, entry buffer, commit strobes and inactivity timer.
   always_ff @(posedge clk_256Hz or negedge reset_n) begin
      if (!reset_n) begin
         state_r        <= ST_IDLE;
         cnt_r          <= 4'd0;
         timer_r        <= 12'd0;
         entry_digits_r <= 16'h0000;
         entry_pm_r     <= 1'b0;
         digit_count_r  <= 3'd0;
         entry_active_r <= 1'b0;
         set_value_r    <= 16'h0000;
         set_pm_r       <= 1'b0;
         load_time_r    <= 1'b0;
         load_alarm_r   <= 1'b0;
         entry_error_r  <= 1'b0;
      end else begin
         load_time_r   <= 1'b0;
         load_alarm_r  <= 1'b0;
         entry_error_r <= 1'b0;

         case (state_r)
            ST_IDLE: begin
               if (kbus.key_held) begin
                  if (DEB_L <= 4'd1) begin
                     state_r <= ST_EXEC;
                     cnt_r   <= 4'd0;
                  end else begin
                     state_r <= ST_PRESS;
                     cnt_r   <= 4'd1;
                  end
               end else begin
                  cnt_r <= 4'd0;
               end
            end
            ST_PRESS: begin
               if (!kbus.key_held) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= 4'd0;
               end else if ((cnt_r + 4'd1) >= DEB_L) begin
                  state_r <= ST_EXEC;
                  cnt_r   <= 4'd0;
               end else begin
                  cnt_r <= cnt_r + 4'd1;
               end
            end
            ST_EXEC: begin
               state_r <= ST_RELEASE;
               cnt_r   <= 4'd0;
            end
            ST_RELEASE: begin
               if (kbus.key_held) begin
                  cnt_r <= 4'd0;
               end else if ((cnt_r + 4'd1) >= DEB_L) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= 4'd0;
               end else begin
                  cnt_r <= cnt_r + 4'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= 4'd0;
            end
         endcase

         // An executed key takes priority over a coincident timeout.
         if (accept_s) begin
            timer_r <= 12'd0;
            if (is_digit_s) begin
               if (digit_count_r < 3'd4) begin
                  entry_digits_r <= {entry_digits_r[11:0], kbus.key_code};
                  digit_count_r  <= digit_count_r + 3'd1;
                  entry_active_r <= 1'b1;
               end else begin
                  entry_digits_r <= entry_digits_r;
               end
            end else begin
               case (kbus.key_code)
                  KEY_AMPM: begin
                     entry_pm_r <= ~entry_pm_r;
                  end
                  KEY_TIME, KEY_ALARM: begin
                     if (entry_valid_s) begin
                        set_value_r  <= entry_digits_r;
                        set_pm_r     <= entry_pm_r;
                        load_time_r  <= (kbus.key_code == KEY_TIME);
                        load_alarm_r <= (kbus.key_code == KEY_ALARM);
                     end else begin
                        entry_error_r <= 1'b1;
                     end
                     entry_digits_r <= 16'h0000;
                     entry_pm_r     <= 1'b0;
                     digit_count_r  <= 3'd0;
                     entry_active_r <= 1'b0;
                  end
                  default: begin
                     entry_pm_r <= entry_pm_r;
                  end
               endcase
            end
         end else if (!(entry_active_r || entry_pm_r)) begin
            timer_r <= 12'd0;
         end else if ((timer_r + 12'd1) >= TMO_L) begin
            timer_r        <= 12'd0;
            entry_digits_r <= 16'h0000;
            entry_pm_r     <= 1'b0;
            digit_count_r  <= 3'd0;
            entry_active_r <= 1'b0;
         end else begin
            timer_r <= timer_r + 12'd1;
         end
      end
   end

   assign kbus.entry_digits = entry_digits_r;
   assign kbus.entry_pm     = entry_pm_r;
   assign kbus.digit_count  = digit_count_r;
   assign kbus.entry_active = entry_active_r;
   assign kbus.set_value    = set_value_r;
   assign kbus.set_pm       = set_pm_r;
   assign kbus.load_time    = load_time_r;
   assign kbus.load_alarm   = load_alarm_r;
   assign kbus.entry_error  = entry_error_r;

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Directed bench for keypad_entry_controller (DEBOUNCE=3, TIMEOUT=20):
// hand-written debounce/latency, timeout and reset sequences plus a
// table of key presses with hand-computed buffer and commit results.
module tb_keypad_entry_controller;

   logic clk_256Hz = 1'b0;
   logic reset_n   = 1'b0;

   keypad_entry_controller_if kb ();

   keypad_entry_controller #(
      .DEBOUNCE (3),
      .TIMEOUT  (20)
   ) dut (
      .clk_256Hz (clk_256Hz),
      .reset_n   (reset_n),
      .kbus      (kb)
   );

   always #5 clk_256Hz = ~clk_256Hz;

   typedef struct {
      logic [3:0]  code;
      logic [15:0] digits;
      logic        pm;
      logic [2:0]  cnt;
      int          lt;
      int          la;
      int          er;
      logic [15:0] setv;
      logic        setpm;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;
   int   n_lt, n_la, n_er, n_multi;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_256Hz);
      #1;
      n_lt += int'(kb.load_time);
      n_la += int'(kb.load_alarm);
      n_er += int'(kb.entry_error);
      if ((int'(kb.load_time) + int'(kb.load_alarm) + int'(kb.entry_error)) > 1) n_multi++;
   endtask

   task automatic clr_pulses();
      n_lt = 0; n_la = 0; n_er = 0; n_multi = 0;
   endtask

   task automatic press_key(input logic [3:0] code, input int hold, input int rel);
      kb.key_code = code;
      kb.key_held = 1'b1;
      for (int i = 0; i < hold; i++) tick();
      kb.key_held = 1'b0;
      for (int i = 0; i < rel; i++) tick();
   endtask

   task automatic add(input logic [3:0] code, input logic [15:0] digits, input logic pm,
                      input logic [2:0] cnt, input int lt, input int la, input int er,
                      input logic [15:0] setv, input logic setpm);
      vec_t v;
      v.code = code; v.digits = digits; v.pm = pm; v.cnt = cnt;
      v.lt = lt; v.la = la; v.er = er; v.setv = setv; v.setpm = setpm;
      vecs.push_back(v);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " digits"}, 32'(kb.entry_digits), 32'h0);
      chk({tag, " pm"},     32'(kb.entry_pm),     32'h0);
      chk({tag, " count"},  32'(kb.digit_count),  32'h0);
      chk({tag, " active"}, 32'(kb.entry_active), 32'h0);
      chk({tag, " setv"},   32'(kb.set_value),    32'h0);
      chk({tag, " setpm"},  32'(kb.set_pm),       32'h0);
      chk({tag, " pulses"}, 32'({kb.load_time, kb.load_alarm, kb.entry_error}), 32'h0);
   endtask

   initial begin
      kb.key_code = 4'h0;
      kb.key_held = 1'b0;
      clr_pulses();

      // ---- table: {code, digits, pm, count, lt, la, er, set_value, set_pm}
      add(4'hB, 16'h0000, 1'b0, 3'd0, 0, 0, 1, 16'h0000, 1'b0); // 1 digit -> error
      add(4'hB, 16'h0000, 1'b0, 3'd0, 0, 0, 1, 16'h0000, 1'b0); // 0 digits -> error
      add(4'h1, 16'h0001, 1'b0, 3'd1, 0, 0, 0, 16'h0000, 1'b0);
      add(4'h1, 16'h0011, 1'b0, 3'd2, 0, 0, 0, 16'h0000, 1'b0);
      add(4'h3, 16'h0113, 1'b0, 3'd3, 0, 0, 0, 16'h0000, 1'b0);
      add(4'h0, 16'h1130, 1'b0, 3'd4, 0, 0, 0, 16'h0000, 1'b0);
      add(4'hA, 16'h1130, 1'b1, 3'd4, 0, 0, 0, 16'h0000, 1'b0);
      add(4'hB, 16'h0000, 1'b0, 3'd0, 1, 0, 0, 16'h1130, 1'b1); // 11:30 PM time
      add(4'h7, 16'h0007, 1'b0, 3'd1, 0, 0, 0, 16'h1130, 1'b1);
      add(4'h4, 16'h0074, 1'b0, 3'd2, 0, 0, 0, 16'h1130, 1'b1);
      add(4'h5, 16'h0745, 1'b0, 3'd3, 0, 0, 0, 16'h1130, 1'b1);
      add(4'hC, 16'h0000, 1'b0, 3'd0, 0, 1, 0, 16'h0745, 1'b0); // 7:45 AM alarm
      add(4'h1, 16'h0001, 1'b0, 3'd1, 0, 0, 0, 16'h0745, 1'b0);
      add(4'h3, 16'h0013, 1'b0, 3'd2, 0, 0, 0, 16'h0745, 1'b0);
      add(4'h0, 16'h0130, 1'b0, 3'd3, 0, 0, 0, 16'h0745, 1'b0);
      add(4'h0, 16'h1300, 1'b0, 3'd4, 0, 0, 0, 16'h0745, 1'b0);
      add(4'hB, 16'h0000, 1'b0, 3'd0, 0, 0, 1, 16'h0745, 1'b0); // hour 13
      add(4'h0, 16'h0000, 1'b0, 3'd1, 0, 0, 0, 16'h0745, 1'b0);
      add(4'h0, 16'h0000, 1'b0, 3'd2, 0, 0, 0, 16'h0745, 1'b0);
      add(4'h0, 16'h0000, 1'b0, 3'd3, 0, 0, 0, 16'h0745, 1'b0);
      add(4'h0, 16'h0000, 1'b0, 3'd4, 0, 0, 0, 16'h0745, 1'b0);
      add(4'hB, 16'h0000, 1'b0, 3'd0, 0, 0, 1, 16'h0745, 1'b0); // hour 0
      add(4'h9, 16'h0009, 1'b0, 3'd1, 0, 0, 0, 16'h0745, 1'b0);
      add(4'h7, 16'h0097, 1'b0, 3'd2, 0, 0, 0, 16'h0745, 1'b0);
      add(4'h0, 16'h0970, 1'b0, 3'd3, 0, 0, 0, 16'h0745, 1'b0);
      add(4'hB, 16'h0000, 1'b0, 3'd0, 0, 0, 1, 16'h0745, 1'b0); // min tens 7
      add(4'h1, 16'h0001, 1'b0, 3'd1, 0, 0, 0, 16'h0745, 1'b0);
      add(4'h2, 16'h0012, 1'b0, 3'd2, 0, 0, 0, 16'h0745, 1'b0);
      add(4'h3, 16'h0123, 1'b0, 3'd3, 0, 0, 0, 16'h0745, 1'b0);
      add(4'h4, 16'h1234, 1'b0, 3'd4, 0, 0, 0, 16'h0745, 1'b0);
      add(4'h5, 16'h1234, 1'b0, 3'd4, 0, 0, 0, 16'h0745, 1'b0); // saturated
      add(4'hF, 16'h1234, 1'b0, 3'd4, 0, 0, 0, 16'h0745, 1'b0); // unused key
      add(4'hB, 16'h0000, 1'b0, 3'd0, 1, 0, 0, 16'h1234, 1'b0); // 12:34 AM time

      // ---- reset state
      tick();
      tick();
      chk_all_zero("reset");
      reset_n = 1'b1;
      tick();
      chk_all_zero("post-reset");

      // ---- glitch: key held 2 cycles then dropped
      clr_pulses();
      press_key(4'h5, 2, 5);
      chk("glitch count",  32'(kb.digit_count),  32'd0);
      chk("glitch digits", 32'(kb.entry_digits), 32'h0);
      chk("glitch pulses", 32'(n_lt + n_la + n_er), 32'd0);

      // ---- latency: action lands on edge 4, no repeat while held
      kb.key_code = 4'h5;
      kb.key_held = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick();
         chk($sformatf("latency edge%0d count", e), 32'(kb.digit_count),
             (e >= 4) ? 32'd1 : 32'd0);
      end
      chk("latency digits", 32'(kb.entry_digits), 32'h0005);
      kb.key_held = 1'b0;
      for (int i = 0; i < 4; i++) tick();

      // ---- table-driven key presses
      for (int i = 0; i < vecs.size(); i++) begin
         clr_pulses();
         press_key(vecs[i].code, 5, 4);
         chk($sformatf("v%0d digits", i), 32'(kb.entry_digits), 32'(vecs[i].digits));
         chk($sformatf("v%0d pm", i),     32'(kb.entry_pm),     32'(vecs[i].pm));
         chk($sformatf("v%0d count", i),  32'(kb.digit_count),  32'(vecs[i].cnt));
         chk($sformatf("v%0d active", i), 32'(kb.entry_active), (vecs[i].cnt != 3'd0) ? 32'd1 : 32'd0);
         chk($sformatf("v%0d load_time", i),  32'(n_lt), 32'(vecs[i].lt));
         chk($sformatf("v%0d load_alarm", i), 32'(n_la), 32'(vecs[i].la));
         chk($sformatf("v%0d entry_error", i), 32'(n_er), 32'(vecs[i].er));
         chk($sformatf("v%0d set_value", i), 32'(kb.set_value), 32'(vecs[i].setv));
         chk($sformatf("v%0d set_pm", i),    32'(kb.set_pm),    32'(vecs[i].setpm));
         chk($sformatf("v%0d exclusive", i), 32'(n_multi), 32'd0);
      end

      // ---- timeout: key 2, then the 20th idle edge clears silently
      clr_pulses();
      kb.key_code = 4'h2;
      kb.key_held = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("tmo accepted", 32'(kb.entry_digits), 32'h0002);
      tick();
      kb.key_held = 1'b0;
      for (int i = 0; i < 18; i++) tick();
      chk("tmo edge19 active", 32'(kb.entry_active), 32'd1);
      chk("tmo edge19 digits", 32'(kb.entry_digits), 32'h0002);
      tick();
      chk("tmo edge20 active", 32'(kb.entry_active), 32'd0);
      chk("tmo edge20 digits", 32'(kb.entry_digits), 32'h0);
      chk("tmo edge20 count",  32'(kb.digit_count),  32'd0);
      chk("tmo pulses", 32'(n_lt + n_la + n_er), 32'd0);
      chk("tmo set_value kept", 32'(kb.set_value), 32'h1234);

      // ---- reset during PRESS, key still held afterwards
      kb.key_code = 4'h3;
      kb.key_held = 1'b1;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      #1;
      reset_n = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         tick();
         chk($sformatf("repress edge%0d count", e), 32'(kb.digit_count),
             (e == 4) ? 32'd1 : 32'd0);
      end
      chk("repress digits", 32'(kb.entry_digits), 32'h0003);
      kb.key_held = 1'b0;
      for (int i = 0; i < 4; i++) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
